// File: rtl/frame_lane_tracker.sv
// ---------------------------------------------------------------------------
// frame_lane_tracker
//
// Purpose:
//   Multi-lane framing classifier. It takes LANES descrambled symbols each
//   cycle (byte plus D/K flag), with lane 0 the earliest. Each symbol is
//   classified as data, TLP/DLLP start/end, EDB or not-valid. Packet context
//   and the in-packet byte count carry across lanes and across cycles.
//   Framing errors are flagged per lane. The block also keeps saturating
//   counts of closed TLPs, correctly sized DLLPs and error bits.
//
// Ports:
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   valid_in   in   1          data_in/dk_in are valid this cycle
//   data_in    in   8*LANES    lane i = data_in[8i+7:8i]
//   dk_in      in   LANES      1 = K symbol, 0 = D symbol, per lane
//   clr_cnt    in   1          synchronous clear of all counters
//   valid_out  out  1          registered copy of valid_in
//   type_out   out  3*LANES    per-lane class (000 data, 001 tlpstart,
//                              010 tlpend, 011 dllpstart, 100 dllpend,
//                              101 tlpedb, 111 not_valid)
//   ctx_out    out  2*LANES    context after each lane (00 idle, 01 tlp,
//                              10 dllp)
//   err_out    out  LANES      per-lane framing error flag
//   tlp_cnt    out  CNT_W      TLPs closed by END (saturating)
//   dllp_cnt   out  CNT_W      DLLPs closed by a correct-length END
//   err_cnt    out  CNT_W      total err_out bits asserted (saturating)
// ---------------------------------------------------------------------------
module frame_lane_tracker #(
  parameter int LANES    = 4,
  parameter int MAX_TLP  = 4096,
  parameter int DLLP_LEN = 6,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [8*LANES-1:0]   data_in,
  input  logic [LANES-1:0]     dk_in,
  input  logic                 clr_cnt,
  output logic                 valid_out,
  output logic [3*LANES-1:0]   type_out,
  output logic [2*LANES-1:0]   ctx_out,
  output logic [LANES-1:0]     err_out,
  output logic [CNT_W-1:0]     tlp_cnt,
  output logic [CNT_W-1:0]     dllp_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  // Byte counter width and per-cycle increment width
  localparam int CW = $clog2(MAX_TLP + 1);
  localparam int IW = $clog2(LANES + 1);

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;

  localparam logic [2:0] T_DATA   = 3'b000;
  localparam logic [2:0] T_TLPSTA = 3'b001;
  localparam logic [2:0] T_TLPEND = 3'b010;
  localparam logic [2:0] T_DLLSTA = 3'b011;
  localparam logic [2:0] T_DLLEND = 3'b100;
  localparam logic [2:0] T_TLPEDB = 3'b101;
  localparam logic [2:0] T_NONE   = 3'b111;

  // State encoding matches the ctx_out encoding so it can be copied out
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TLP  = 2'b01,
    ST_DLLP = 2'b10
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   count_q, count_n;

  logic [3*LANES-1:0] type_n;
  logic [2*LANES-1:0] ctx_n;
  logic [LANES-1:0]   err_n;
  logic [IW-1:0]      tlp_inc, dllp_inc, err_inc;

  logic [7:0]         lane_sym;
  logic               lane_k;
  logic [2:0]         lane_t;
  logic               lane_e;

  // Adds a small per-cycle increment to a counter, sticking at all-ones
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [IW-1:0]    b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // State and byte count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
    end
  end

  // Lane-by-lane classifier: each lane works on the state left by the
  // previous lane, so a packet may open and close within one cycle.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    type_n   = '1;
    ctx_n    = '0;
    err_n    = '0;
    tlp_inc  = '0;
    dllp_inc = '0;
    err_inc  = '0;
    lane_sym = '0;
    lane_k   = 1'b0;
    lane_t   = T_NONE;
    lane_e   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_sym = data_in[8*i +: 8];
      lane_k   = dk_in[i];
      lane_t   = T_NONE;
      lane_e   = 1'b0;
      if (valid_in) begin
        if (lane_k) begin
          case (lane_sym)
            SYM_STP: begin
              lane_t  = T_TLPSTA;
              lane_e  = (state_n != ST_IDLE);
              state_n = ST_TLP;
              count_n = '0;
            end
            SYM_SDP: begin
              lane_t  = T_DLLSTA;
              lane_e  = (state_n != ST_IDLE);
              state_n = ST_DLLP;
              count_n = '0;
            end
            SYM_END: begin
              case (state_n)
                ST_TLP: begin
                  lane_t  = T_TLPEND;
                  tlp_inc = tlp_inc + IW'(1);
                end
                ST_DLLP: begin
                  lane_t = T_DLLEND;
                  if (count_n == CW'(DLLP_LEN)) dllp_inc = dllp_inc + IW'(1);
                  else                          lane_e   = 1'b1;
                end
                default: lane_e = 1'b1;
              endcase
              state_n = ST_IDLE;
            end
            SYM_EDB: begin
              if (state_n == ST_TLP) lane_t = T_TLPEDB;
              else                   lane_e = 1'b1;
              state_n = ST_IDLE;
            end
            default: begin
              // PAD or unknown K: harmless between packets, aborts a packet
              lane_e  = (state_n != ST_IDLE);
              state_n = ST_IDLE;
            end
          endcase
        end else if (state_n != ST_IDLE) begin
          lane_t = T_DATA;
          if (state_n == ST_DLLP) begin
            // Over-long DLLP keeps counting so its END also reports a bad length
            if (count_n == CW'(DLLP_LEN)) lane_e = 1'b1;
            if (count_n != CW'(MAX_TLP))  count_n = count_n + CW'(1);
          end else if (count_n == CW'(MAX_TLP)) begin
            lane_e  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            count_n = count_n + CW'(1);
          end
        end
      end
      type_n[3*i +: 3] = lane_t;
      ctx_n[2*i +: 2]  = state_n;
      err_n[i]         = lane_e;
      err_inc          = err_inc + IW'(lane_e);
    end
  end

  // Registered per-lane outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      type_out  <= '1;
      ctx_out   <= '0;
      err_out   <= '0;
    end else begin
      valid_out <= valid_in;
      type_out  <= type_n;
      ctx_out   <= ctx_n;
      err_out   <= err_n;
    end
  end

  // Statistics counters; a clear wins over any increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_cnt  <= '0;
      dllp_cnt <= '0;
      err_cnt  <= '0;
    end else if (clr_cnt) begin
      tlp_cnt  <= '0;
      dllp_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      tlp_cnt  <= sat_add(tlp_cnt,  tlp_inc);
      dllp_cnt <= sat_add(dllp_cnt, dllp_inc);
      err_cnt  <= sat_add(err_cnt,  err_inc);
    end
  end

endmodule

// File: tb/tb_frame_lane_tracker.sv
// ---------------------------------------------------------------------------
// tb_frame_lane_tracker
//
// Purpose:
//   Directed bench for frame_lane_tracker with LANES=4. Each scenario task
//   drives symbol cycles and compares registered outputs against
//   hand-computed values one cycle later.
// ---------------------------------------------------------------------------
module tb_frame_lane_tracker;

  localparam int LANES = 4;
  localparam int CNT_W = 16;

  logic               clk;
  logic               rst_n;
  logic               valid_in;
  logic [8*LANES-1:0] data_in;
  logic [LANES-1:0]   dk_in;
  logic               clr_cnt;
  logic               valid_out;
  logic [3*LANES-1:0] type_out;
  logic [2*LANES-1:0] ctx_out;
  logic [LANES-1:0]   err_out;
  logic [CNT_W-1:0]   tlp_cnt;
  logic [CNT_W-1:0]   dllp_cnt;
  logic [CNT_W-1:0]   err_cnt;

  int vectors;
  int miscompares;

  frame_lane_tracker #(
    .LANES(LANES), .MAX_TLP(4096), .DLLP_LEN(6), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .dk_in(dk_in), .clr_cnt(clr_cnt), .valid_out(valid_out),
    .type_out(type_out), .ctx_out(ctx_out), .err_out(err_out),
    .tlp_cnt(tlp_cnt), .dllp_cnt(dllp_cnt), .err_cnt(err_cnt)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one symbol cycle; outputs are sampled 1 unit after the edge
  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic clr);
    valid_in = v;
    data_in  = d;
    dk_in    = k;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; dk_in = '0; clr_cnt = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    vectors++; if (type_out !== 12'hFFF) begin miscompares++; $display("[TB] FAIL reset_type got %h exp fff", type_out); end
    vectors++; if ({valid_out, ctx_out, err_out} !== 13'h0) begin miscompares++; $display("[TB] FAIL reset_flags got %h exp 0", {valid_out, ctx_out, err_out}); end
    vectors++; if ({tlp_cnt, dllp_cnt, err_cnt} !== 48'h0) begin miscompares++; $display("[TB] FAIL reset_cnt got %h exp 0", {tlp_cnt, dllp_cnt, err_cnt}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_tlp_single();
    drive(1'b1, {8'hFD, 8'h02, 8'h01, 8'hFB}, 4'b1001, 1'b0);
    vectors++; if (type_out !== 12'b010_000_000_001) begin miscompares++; $display("[TB] FAIL tlp_type got %b exp 010000000001", type_out); end
    vectors++; if (ctx_out !== 8'b00_01_01_01) begin miscompares++; $display("[TB] FAIL tlp_ctx got %b exp 00010101", ctx_out); end
    vectors++; if (err_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL tlp_err got %b exp 0000", err_out); end
    vectors++; if (tlp_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL tlp_cnt got %0d exp 1", tlp_cnt); end
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("[TB] FAIL tlp_valid got %b exp 1", valid_out); end
  endtask

  task automatic test_dllp();
    // Correct length: 3 + 3 data bytes
    drive(1'b1, {8'h13, 8'h12, 8'h11, 8'h5C}, 4'b0001, 1'b0);
    vectors++; if (type_out !== 12'b000_000_000_011) begin miscompares++; $display("[TB] FAIL dllp_start_type got %b exp 000000000011", type_out); end
    vectors++; if (ctx_out !== 8'b10_10_10_10) begin miscompares++; $display("[TB] FAIL dllp_start_ctx got %b exp 10101010", ctx_out); end
    drive(1'b1, {8'hFD, 8'h16, 8'h15, 8'h14}, 4'b1000, 1'b0);
    vectors++; if (type_out !== 12'b100_000_000_000) begin miscompares++; $display("[TB] FAIL dllp_end_type got %b exp 100000000000", type_out); end
    vectors++; if (ctx_out !== 8'b00_10_10_10) begin miscompares++; $display("[TB] FAIL dllp_end_ctx got %b exp 00101010", ctx_out); end
    vectors++; if (err_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL dllp_end_err got %b exp 0000", err_out); end
    vectors++; if (dllp_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL dllp_cnt got %0d exp 1", dllp_cnt); end
    // Short: 3 + 2 data bytes, then a D byte back in idle
    drive(1'b1, {8'h13, 8'h12, 8'h11, 8'h5C}, 4'b0001, 1'b0);
    drive(1'b1, {8'h33, 8'hFD, 8'h15, 8'h14}, 4'b0100, 1'b0);
    vectors++; if (type_out !== 12'b111_100_000_000) begin miscompares++; $display("[TB] FAIL dllp_short_type got %b exp 111100000000", type_out); end
    vectors++; if (err_out !== 4'b0100) begin miscompares++; $display("[TB] FAIL dllp_short_err got %b exp 0100", err_out); end
    vectors++; if (dllp_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL dllp_short_cnt got %0d exp 1", dllp_cnt); end
    vectors++; if (err_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL dllp_short_errcnt got %0d exp 1", err_cnt); end
  endtask

  task automatic test_abort();
    drive(1'b1, {8'h22, 8'h5C, 8'h21, 8'hFB}, 4'b0101, 1'b0);
    vectors++; if (type_out !== 12'b000_011_000_001) begin miscompares++; $display("[TB] FAIL abort_type got %b exp 000011000001", type_out); end
    vectors++; if (err_out !== 4'b0100) begin miscompares++; $display("[TB] FAIL abort_err got %b exp 0100", err_out); end
    vectors++; if (ctx_out !== 8'b10_10_01_01) begin miscompares++; $display("[TB] FAIL abort_ctx got %b exp 10100101", ctx_out); end
    vectors++; if (err_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL abort_errcnt got %0d exp 2", err_cnt); end
    // DLLP context carries into the next cycle (count goes 1 -> 5)
    drive(1'b1, {8'h26, 8'h25, 8'h24, 8'h23}, 4'b0000, 1'b0);
    vectors++; if (type_out !== 12'b000_000_000_000) begin miscompares++; $display("[TB] FAIL carry_type got %b exp 000000000000", type_out); end
    vectors++; if (ctx_out !== 8'b10_10_10_10) begin miscompares++; $display("[TB] FAIL carry_ctx got %b exp 10101010", ctx_out); end
    // Sixth byte then END closes a correct-length DLLP
    drive(1'b1, {8'h29, 8'h28, 8'hFD, 8'h27}, 4'b0010, 1'b0);
    vectors++; if (type_out !== 12'b111_111_100_000) begin miscompares++; $display("[TB] FAIL carry_end_type got %b exp 111111100000", type_out); end
    vectors++; if (dllp_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL carry_dllp_cnt got %0d exp 2", dllp_cnt); end
  endtask

  task automatic test_idle_k();
    drive(1'b1, {8'h40, 8'hF7, 8'hFE, 8'hFD}, 4'b0111, 1'b0);
    vectors++; if (type_out !== 12'hFFF) begin miscompares++; $display("[TB] FAIL idle_k_type got %b exp all ones", type_out); end
    vectors++; if (err_out !== 4'b0011) begin miscompares++; $display("[TB] FAIL idle_k_err got %b exp 0011", err_out); end
    vectors++; if (err_cnt !== 16'd4) begin miscompares++; $display("[TB] FAIL idle_k_errcnt got %0d exp 4", err_cnt); end
  endtask

  task automatic test_hold();
    drive(1'b1, {8'h53, 8'h52, 8'h51, 8'hFB}, 4'b0001, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, {8'hFD, 8'hFD, 8'hFD, 8'hFD}, 4'b1111, 1'b0);
      vectors++; if ({valid_out, type_out, err_out} !== {1'b0, 12'hFFF, 4'b0000}) begin miscompares++; $display("[TB] FAIL hold_idle_out got %h exp 0fff0", {valid_out, type_out, err_out}); end
      vectors++; if (ctx_out !== 8'b01_01_01_01) begin miscompares++; $display("[TB] FAIL hold_ctx got %b exp 01010101", ctx_out); end
    end
    vectors++; if ({tlp_cnt, dllp_cnt, err_cnt} !== {16'd1, 16'd2, 16'd4}) begin miscompares++; $display("[TB] FAIL hold_cnt got %h exp 000100020004", {tlp_cnt, dllp_cnt, err_cnt}); end
    drive(1'b1, {8'h56, 8'h55, 8'hFE, 8'h54}, 4'b0010, 1'b0);
    vectors++; if (type_out !== 12'b111_111_101_000) begin miscompares++; $display("[TB] FAIL edb_type got %b exp 111111101000", type_out); end
    vectors++; if ({err_out, tlp_cnt} !== {4'b0000, 16'd1}) begin miscompares++; $display("[TB] FAIL edb_err_cnt got %h exp 00001", {err_out, tlp_cnt}); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, {8'h63, 8'h62, 8'h61, 8'hFB}, 4'b0001, 1'b0);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if ({type_out, tlp_cnt, err_cnt} !== {12'hFFF, 16'd0, 16'd0}) begin miscompares++; $display("[TB] FAIL async_reset got %h exp fff00000000", {type_out, tlp_cnt, err_cnt}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, {8'h66, 8'h65, 8'h64, 8'hFD}, 4'b0001, 1'b0);
    vectors++; if (type_out !== 12'hFFF) begin miscompares++; $display("[TB] FAIL lost_ctx_type got %b exp all ones", type_out); end
    vectors++; if (err_out !== 4'b0001) begin miscompares++; $display("[TB] FAIL lost_ctx_err got %b exp 0001", err_out); end
    vectors++; if (err_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL lost_ctx_errcnt got %0d exp 1", err_cnt); end
  endtask

  task automatic test_max_tlp();
    // STP + 3 bytes, then 1023 full cycles: 4095 bytes total
    drive(1'b1, {8'h03, 8'h02, 8'h01, 8'hFB}, 4'b0001, 1'b0);
    for (int c = 0; c < 1023; c++) drive(1'b1, 32'hA5A5A5A5, 4'b0000, 1'b0);
    vectors++; if (ctx_out !== 8'b01_01_01_01) begin miscompares++; $display("[TB] FAIL max_tlp_ctx got %b exp 01010101", ctx_out); end
    // Byte 4096 is allowed, byte 4097 overruns and drops to idle
    drive(1'b1, {8'h77, 8'hFD, 8'h76, 8'h75}, 4'b0100, 1'b0);
    vectors++; if (type_out !== 12'b111_111_000_000) begin miscompares++; $display("[TB] FAIL max_tlp_type got %b exp 111111000000", type_out); end
    vectors++; if (err_out !== 4'b0110) begin miscompares++; $display("[TB] FAIL max_tlp_err got %b exp 0110", err_out); end
    vectors++; if (ctx_out !== 8'b00_00_00_01) begin miscompares++; $display("[TB] FAIL max_tlp_ctx_end got %b exp 00000001", ctx_out); end
    vectors++; if ({tlp_cnt, err_cnt} !== {16'd0, 16'd3}) begin miscompares++; $display("[TB] FAIL max_tlp_cnt got %h exp 00000003", {tlp_cnt, err_cnt}); end
  endtask

  task automatic test_dllp_over();
    drive(1'b1, {8'h83, 8'h82, 8'h81, 8'h5C}, 4'b0001, 1'b0);
    drive(1'b1, {8'h87, 8'h86, 8'h85, 8'h84}, 4'b0000, 1'b0);
    vectors++; if (type_out !== 12'b000_000_000_000) begin miscompares++; $display("[TB] FAIL dllp_over_type got %b exp 000000000000", type_out); end
    vectors++; if (err_out !== 4'b1000) begin miscompares++; $display("[TB] FAIL dllp_over_err got %b exp 1000", err_out); end
    vectors++; if (ctx_out !== 8'b10_10_10_10) begin miscompares++; $display("[TB] FAIL dllp_over_ctx got %b exp 10101010", ctx_out); end
    drive(1'b1, {8'h00, 8'h00, 8'h00, 8'hFE}, 4'b0001, 1'b0);
  endtask

  task automatic test_back_to_back();
    // clr_cnt wins over two same-cycle END symbols
    drive(1'b1, {8'hFD, 8'hFB, 8'hFD, 8'hFB}, 4'b1111, 1'b1);
    vectors++; if ({tlp_cnt, dllp_cnt, err_cnt} !== 48'h0) begin miscompares++; $display("[TB] FAIL clr_priority got %h exp 0", {tlp_cnt, dllp_cnt, err_cnt}); end
    vectors++; if (type_out !== 12'b010_001_010_001) begin miscompares++; $display("[TB] FAIL b2b_type got %b exp 010001010001", type_out); end
    vectors++; if (err_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL b2b_err got %b exp 0000", err_out); end
    for (int c = 0; c < 32767; c++) drive(1'b1, {8'hFD, 8'hFB, 8'hFD, 8'hFB}, 4'b1111, 1'b0);
    vectors++; if (tlp_cnt !== 16'hFFFE) begin miscompares++; $display("[TB] FAIL sat_near got %h exp fffe", tlp_cnt); end
    drive(1'b1, {8'hFD, 8'hFB, 8'hFD, 8'hFB}, 4'b1111, 1'b0);
    vectors++; if (tlp_cnt !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_reach got %h exp ffff", tlp_cnt); end
    drive(1'b1, {8'hFD, 8'hFB, 8'hFD, 8'hFB}, 4'b1111, 1'b0);
    vectors++; if (tlp_cnt !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_hold got %h exp ffff", tlp_cnt); end
    drive(1'b1, {8'hFD, 8'hFB, 8'hFD, 8'hFB}, 4'b1111, 1'b1);
    vectors++; if (tlp_cnt !== 16'h0) begin miscompares++; $display("[TB] FAIL clr_from_sat got %h exp 0", tlp_cnt); end
  endtask

  // Scenario sequence
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_tlp_single();
    test_dllp();
    test_abort();
    test_idle_k();
    test_hold();
    test_reset_mid();
    test_max_tlp();
    test_dllp_over();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
